// File: rtl/spi_host_lane_select.sv
// -----------------------------------------------------------------------------
// spi_host_lane_select
//
// Word-to-lane dispenser for the SPI Host TX datapath. Accepts a WordW-bit
// word with per-lane enables and hands out only the enabled LaneW-bit lanes,
// one per handshake. The lane order is LSB-first or MSB-first, chosen per
// word. Disabled lanes are skipped by a combinational priority encoder, so
// they take no cycles.
//
// Optional feature macro: SPI_HOST_LANE_SELECT_SKID_EN
//   undefined : single active slot; one refill bubble between words.
//   defined   : extra pending slot; lanes stream one per cycle across words.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   word_i         input word; lane k = word_i[LaneW*k +: LaneW]
//   word_be_i      per-lane enables; bit k enables lane k
//   msb_first_i    lane order for this word, sampled on acceptance
//   word_valid_i   word valid
//   word_ready_o   word accepted on word_valid_i & word_ready_o
//   lane_o         current lane data (0 when idle)
//   lane_valid_o   lane valid
//   lane_last_o    current lane is the final enabled lane of its word
//   lane_ready_i   lane consumed on lane_valid_o & lane_ready_i
//   lanes_left_o   number of lanes still pending in the active slot
//   flush_i        discard all held data
//   sw_rst_i       software reset, same effect as flush_i
// -----------------------------------------------------------------------------
module spi_host_lane_select #(
  parameter int  WordW    = 32,
  parameter int  LaneW    = 8,
  localparam int NumLanes = WordW / LaneW,
  localparam int CntW     = $clog2(NumLanes + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WordW-1:0]    word_i,
  input  logic [NumLanes-1:0] word_be_i,
  input  logic                msb_first_i,
  input  logic                word_valid_i,
  output logic                word_ready_o,
  output logic [LaneW-1:0]    lane_o,
  output logic                lane_valid_o,
  output logic                lane_last_o,
  input  logic                lane_ready_i,
  output logic [CntW-1:0]     lanes_left_o,
  input  logic                flush_i,
  input  logic                sw_rst_i
);

  localparam int IdxW = $clog2(NumLanes);

  if ((WordW % LaneW) != 0 || NumLanes < 2) begin : g_param_check
    $error("spi_host_lane_select: WordW must be a multiple of LaneW giving at least 2 lanes");
  end

  // Active slot
  logic [WordW-1:0]    r_word, w_word_nxt;
  logic [NumLanes-1:0] r_mask, w_mask_nxt;
  logic                r_order, w_order_nxt;

`ifdef SPI_HOST_LANE_SELECT_SKID_EN
  // Pending slot
  logic [WordW-1:0]    r_pnd_word, w_pnd_word_nxt;
  logic [NumLanes-1:0] r_pnd_mask, w_pnd_mask_nxt;
  logic                r_pnd_order, w_pnd_order_nxt;
  logic                w_act_free;
`endif

  logic                w_clr;
  logic                w_word_accept;
  logic                w_lane_fire;
  logic [IdxW-1:0]     w_sel_idx;
  logic [NumLanes-1:0] w_sel_oh;
  logic [CntW-1:0]     w_popcnt;
  logic [LaneW-1:0]    w_lane;

  assign w_clr = flush_i | sw_rst_i;

  // ---------------------------------------------------------------------------
  // Lane selection: lowest set mask bit for LSB-first, highest for MSB-first.
  // In each loop the last match wins, so the scan direction picks the end.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    w_sel_idx = '0;
    if (r_order) begin
      for (int k = 0; k < NumLanes; k++) begin
        if (r_mask[k]) w_sel_idx = IdxW'(k);
      end
    end else begin
      for (int k = NumLanes - 1; k >= 0; k--) begin
        if (r_mask[k]) w_sel_idx = IdxW'(k);
      end
    end
  end

  assign w_sel_oh = NumLanes'(1) << w_sel_idx;

  always_comb begin
    w_popcnt = '0;
    for (int k = 0; k < NumLanes; k++) begin
      w_popcnt = w_popcnt + CntW'(r_mask[k]);
    end
  end

  always_comb begin
    w_lane = '0;
    for (int k = 0; k < NumLanes; k++) begin
      if (lane_valid_o && (IdxW'(k) == w_sel_idx)) w_lane = r_word[k*LaneW +: LaneW];
    end
  end

  assign lane_valid_o = |r_mask;
  assign lane_o       = w_lane;
  assign lane_last_o  = lane_valid_o & (w_popcnt == CntW'(1));
  assign lanes_left_o = w_popcnt;
  assign w_lane_fire  = lane_valid_o & lane_ready_i;

  // Ready depends only on held state and the clear inputs, never on the
  // lane-side handshake, so no combinational path runs through this block.
`ifdef SPI_HOST_LANE_SELECT_SKID_EN
  assign word_ready_o = ~w_clr & ~(|r_pnd_mask);
  // The active slot can take a new word when empty, or when its final lane
  // leaves this cycle.
  assign w_act_free   = ~(|r_mask) | (w_lane_fire & lane_last_o);
`else
  assign word_ready_o = ~w_clr & ~(|r_mask);
`endif

  assign w_word_accept = word_valid_i & word_ready_o;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_word_nxt  = r_word;
    w_mask_nxt  = r_mask;
    w_order_nxt = r_order;

    if (w_lane_fire) w_mask_nxt = r_mask & ~w_sel_oh;

`ifdef SPI_HOST_LANE_SELECT_SKID_EN
    w_pnd_word_nxt  = r_pnd_word;
    w_pnd_mask_nxt  = r_pnd_mask;
    w_pnd_order_nxt = r_pnd_order;

    if (w_act_free) begin
      if (|r_pnd_mask) begin
        w_word_nxt     = r_pnd_word;
        w_mask_nxt     = r_pnd_mask;
        w_order_nxt    = r_pnd_order;
        w_pnd_mask_nxt = '0;
      end else if (w_word_accept) begin
        // An all-zero-enable word lands with an empty mask and is gone.
        w_word_nxt  = word_i;
        w_mask_nxt  = word_be_i;
        w_order_nxt = msb_first_i;
      end
    end else if (w_word_accept && (|word_be_i)) begin
      w_pnd_word_nxt  = word_i;
      w_pnd_mask_nxt  = word_be_i;
      w_pnd_order_nxt = msb_first_i;
    end
`else
    // Acceptance only happens with an empty mask, so it never races a lane.
    if (w_word_accept) begin
      w_word_nxt  = word_i;
      w_mask_nxt  = word_be_i;
      w_order_nxt = msb_first_i;
    end
`endif

    // Clear overrides everything, including a lane handshake this cycle.
    if (w_clr) begin
      w_word_nxt  = '0;
      w_mask_nxt  = '0;
      w_order_nxt = 1'b0;
`ifdef SPI_HOST_LANE_SELECT_SKID_EN
      w_pnd_word_nxt  = '0;
      w_pnd_mask_nxt  = '0;
      w_pnd_order_nxt = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order.
    if (!rst_ni) begin
      r_word  <= '0;
      r_mask  <= '0;
      r_order <= 1'b0;
`ifdef SPI_HOST_LANE_SELECT_SKID_EN
      r_pnd_word  <= '0;
      r_pnd_mask  <= '0;
      r_pnd_order <= 1'b0;
`endif
    end else begin
      r_word  <= w_word_nxt;
      r_mask  <= w_mask_nxt;
      r_order <= w_order_nxt;
`ifdef SPI_HOST_LANE_SELECT_SKID_EN
      r_pnd_word  <= w_pnd_word_nxt;
      r_pnd_mask  <= w_pnd_mask_nxt;
      r_pnd_order <= w_pnd_order_nxt;
`endif
    end
  end

endmodule
